// File: rtl/enc_pkg.sv
// Shared definitions for the 8-to-3 queued encoder and its 3-to-8 decoder partner.
// Contents:
//   ENC_N, ENC_CODE_W  - number of request lines and code width
//   enc_code_t         - 3-bit code type
//   enc_state_t        - offer FSM states (IDLE / OFFER)
//   enc_onehot()       - code -> one-hot line; the encoder clears pending bits with
//                        this same mapping, so encoder and decoder always agree.
package enc_pkg;

  localparam int ENC_N      = 8;
  localparam int ENC_CODE_W = 3;

  typedef logic [ENC_CODE_W-1:0] enc_code_t;

  typedef enum logic {
    ENC_IDLE  = 1'b0,
    ENC_OFFER = 1'b1
  } enc_state_t;

  function automatic logic [ENC_N-1:0] enc_onehot(input enc_code_t code);
    logic [ENC_N-1:0] v;
    v = {{(ENC_N-1){1'b0}}, 1'b1} << code;
    return v;
  endfunction

endpackage

// File: rtl/enc_sel8.sv
// Combinational 8-way circular priority search.
// Ports:
//   i_vec   - candidate vector
//   i_start - index examined first
//   i_up    - 1: search start, start+1, ... ; 0: start, start-1, ... (wrapping mod 8)
//   o_idx   - first set index in search order (i_start when nothing is set)
//   o_found - at least one bit of i_vec is set
module enc_sel8
  import enc_pkg::*;
(
  input  logic [ENC_N-1:0] i_vec,
  input  enc_code_t        i_start,
  input  logic             i_up,
  output enc_code_t        o_idx,
  output logic             o_found
);

  enc_code_t w_cand;

  // Walk the eight positions in search order; the first hit wins.
  always_comb begin
    o_idx   = i_start;
    o_found = 1'b0;
    w_cand  = i_start;
    for (int i = 0; i < ENC_N; i++) begin
      // 3-bit arithmetic gives the 7->0 / 0->7 wrap for free
      if (i_up) begin
        w_cand = i_start + enc_code_t'(i);
      end else begin
        w_cand = i_start - enc_code_t'(i);
      end
      if (!o_found && i_vec[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/enc_8to3_queue.sv
// Sequential 8-to-3 encoder with pending queue and valid/ready output.
// Request pulses on REQ_I are latched into a pending register; one index per
// accepted transfer is offered on CODE_O. An offered code is never preempted.
// Ports:
//   CLK, RST  - clock, asynchronous active-high reset
//   REQ_I     - request pulses (bit k queues index k)
//   READY_I   - consumer accepts CODE_O this cycle
//   VALID_O   - CODE_O holds a queued index
//   CODE_O    - offered index
//   PEND_O    - queued, not yet offered requests
//   OVF_O     - one-cycle pulse: a request hit an already-pending bit
// Parameter LSB_FIRST: 1 = bit 0 highest priority, 0 = bit 7 highest.
// Macro ENC_ROUND_ROBIN_EN: when defined, selection is round-robin starting at
// the index after the last loaded code, and LSB_FIRST is ignored.
module enc_8to3_queue
  import enc_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [ENC_N-1:0] REQ_I,
  input  logic             READY_I,
  output logic             VALID_O,
  output enc_code_t        CODE_O,
  output logic [ENC_N-1:0] PEND_O,
  output logic             OVF_O
);

  enc_state_t       r_state;
  enc_state_t       w_next_state;
  logic [ENC_N-1:0] r_pend;
  enc_code_t        r_code;
  logic             r_ovf;
  logic [ENC_N-1:0] w_p_eff;
  logic             w_load;
  enc_code_t        w_sel;
  logic             w_found;
  enc_code_t        w_start;
  logic             w_up;

`ifdef ENC_ROUND_ROBIN_EN
  enc_code_t        r_ptr;
  assign w_start = r_ptr;
  assign w_up    = 1'b1;
`else
  assign w_start = LSB_FIRST ? 3'd0 : 3'd7;
  assign w_up    = LSB_FIRST;
`endif

  // Requests arriving this cycle are eligible for selection immediately.
  assign w_p_eff = r_pend | REQ_I;
  assign w_load  = (r_state == ENC_IDLE) || READY_I;

  enc_sel8 u_sel (
    .i_vec   (w_p_eff),
    .i_start (w_start),
    .i_up    (w_up),
    .o_idx   (w_sel),
    .o_found (w_found)
  );

  // Offer state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ENC_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Offer next-state: an offer is only left when the consumer takes it.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ENC_IDLE: begin
        if (w_found) begin
          w_next_state = ENC_OFFER;
        end else begin
          w_next_state = ENC_IDLE;
        end
      end
      ENC_OFFER: begin
        if (READY_I) begin
          w_next_state = w_found ? ENC_OFFER : ENC_IDLE;
        end else begin
          w_next_state = ENC_OFFER;
        end
      end
      default: w_next_state = ENC_IDLE;
    endcase
  end

  // Offer outputs decoded from the state register.
  always_comb begin
    case (r_state)
      ENC_OFFER: VALID_O = 1'b1;
      ENC_IDLE:  VALID_O = 1'b0;
      default:   VALID_O = 1'b0;
    endcase
  end

  // Pending queue, offered code, overflow flag and round-robin pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pend <= 8'h00;
      r_code <= 3'd0;
      r_ovf  <= 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
      r_ptr  <= 3'd0;
`endif
    end else begin
      // Overflow compares against the queue only: a repeat of the offered
      // code is a fresh event and is simply queued.
      r_ovf <= |(REQ_I & r_pend);
      if (w_load) begin
        if (w_found) begin
          r_code <= w_sel;
          r_pend <= w_p_eff & ~enc_onehot(w_sel);
`ifdef ENC_ROUND_ROBIN_EN
          r_ptr  <= w_sel + 3'd1;
`endif
        end else begin
          r_pend <= 8'h00;
        end
      end else begin
        r_pend <= w_p_eff;
      end
    end
  end

  assign CODE_O = r_code;
  assign PEND_O = r_pend;
  assign OVF_O  = r_ovf;

endmodule

// File: tb/tb_enc_8to3_queue.sv
// Self-checking bench for enc_8to3_queue (default build or ENC_ROUND_ROBIN_EN).
module tb_enc_8to3_queue;
  import enc_pkg::*;

  localparam bit TB_LSB_FIRST = 1'b1;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] REQ_I;
  logic       READY_I;
  logic       VALID_O;
  logic [2:0] CODE_O;
  logic [7:0] PEND_O;
  logic       OVF_O;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] m_pend;
  logic       m_valid;
  logic [2:0] m_code;
  logic       m_ovf;
  int         m_ptr;

  // observed handshakes
  logic [7:0] hs_or;
  logic [7:0] req_or;
  int         hs_cnt [8];

  enc_8to3_queue #(.LSB_FIRST(TB_LSB_FIRST)) dut (
    .CLK(CLK), .RST(RST), .REQ_I(REQ_I), .READY_I(READY_I),
    .VALID_O(VALID_O), .CODE_O(CODE_O), .PEND_O(PEND_O), .OVF_O(OVF_O)
  );

  always #5 CLK = ~CLK;

  // Selected index from a nonzero pending set, computed arithmetically.
  function automatic int pick(input logic [7:0] p, input int ptr);
`ifdef ENC_ROUND_ROBIN_EN
    logic [15:0] d;
    logic [7:0]  r;
    d = {p, p} >> ptr;
    r = d[7:0];
    return ($clog2(int'(r & (~r + 8'd1))) + ptr) % 8;
`else
    if (TB_LSB_FIRST) return $clog2(int'(p & (~p + 8'd1)));
    else              return $clog2(int'(p) + 1) - 1 + (ptr * 0);
`endif
  endfunction

  function automatic void model_reset();
    m_pend = 8'h00; m_valid = 1'b0; m_code = 3'd0; m_ovf = 1'b0; m_ptr = 0;
  endfunction

  function automatic void model_step(input logic [7:0] req, input logic rdy);
    logic [7:0] pe;
    int s;
    pe = m_pend | req;
    m_ovf = ((req & m_pend) != 8'h00);
    if (!m_valid || rdy) begin
      if (pe != 8'h00) begin
        s = pick(pe, m_ptr);
        m_code  = 3'(s);
        m_valid = 1'b1;
        m_pend  = pe & ~(8'h01 << s);
        m_ptr   = (s + 1) % 8;
      end else begin
        m_valid = 1'b0;
        m_pend  = 8'h00;
      end
    end else begin
      m_pend = pe;
    end
  endfunction

  // Drive one cycle at the falling edge; outputs are settled 1 time unit after the rising edge.
  task automatic drive(input logic [7:0] req, input logic rdy);
    @(negedge CLK);
    if (VALID_O && rdy) begin
      hs_or = hs_or | enc_onehot(CODE_O);
      hs_cnt[CODE_O] = hs_cnt[CODE_O] + 1;
    end
    req_or  = req_or | req;
    REQ_I   = req;
    READY_I = rdy;
    model_step(req, rdy);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; REQ_I = 8'h00; READY_I = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    hs_or = 8'h00; req_or = 8'h00;
    for (int i = 0; i < 8; i++) hs_cnt[i] = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ_I = 8'h00; READY_I = 1'b0;
    #1;
    checks++;
    if ({VALID_O, CODE_O, PEND_O, OVF_O} !== 13'h0) begin
      errors++;
      $display("FAIL reset_init: got v=%0b c=%0d p=%h o=%0b, expected all 0", VALID_O, CODE_O, PEND_O, OVF_O);
    end
    do_reset();
    drive(8'h10, 1'b0);
    drive(8'h11, 1'b0);
    drive(8'h01, 1'b0);
    checks++;
    if ({VALID_O, CODE_O, PEND_O, OVF_O} !== {1'b1, 3'd4, 8'h11, 1'b1}) begin
      errors++;
      $display("FAIL reset_setup: got v=%0b c=%0d p=%h o=%0b, expected 1 4 11 1", VALID_O, CODE_O, PEND_O, OVF_O);
    end
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({VALID_O, CODE_O, PEND_O, OVF_O} !== 13'h0) begin
      errors++;
      $display("FAIL reset_async: got v=%0b c=%0d p=%h o=%0b, expected all 0", VALID_O, CODE_O, PEND_O, OVF_O);
    end
    do_reset();
  endtask

  task automatic test_priority();
    logic [2:0] exp_codes [3];
    exp_codes[0] = 3'd2; exp_codes[1] = 3'd4; exp_codes[2] = 3'd7;
    do_reset();
    drive(8'b1001_0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (!(VALID_O === 1'b1 && CODE_O === exp_codes[i])) begin
        errors++;
        $display("FAIL prio_code%0d: got v=%0b c=%0d, expected v=1 c=%0d", i, VALID_O, CODE_O, exp_codes[i]);
      end
      drive(8'h00, 1'b1);
    end
    checks++;
    if (VALID_O !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle: got v=%0b, expected 0", VALID_O);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(8'h08, 1'b0);
    drive(8'h01, 1'b0);
    drive(8'h00, 1'b0);
    checks++;
    if ({VALID_O, CODE_O, PEND_O} !== {1'b1, 3'd3, 8'h01}) begin
      errors++;
      $display("FAIL bp_hold: got v=%0b c=%0d p=%h, expected 1 3 01", VALID_O, CODE_O, PEND_O);
    end
    drive(8'h00, 1'b1);
    checks++;
    if ({VALID_O, CODE_O, PEND_O} !== {1'b1, 3'd0, 8'h00}) begin
      errors++;
      $display("FAIL bp_next: got v=%0b c=%0d p=%h, expected 1 0 00", VALID_O, CODE_O, PEND_O);
    end
  endtask

  task automatic test_overflow();
    logic [2:0] ovf_seen;
    do_reset();
    drive(8'h20, 1'b0); ovf_seen[0] = OVF_O;
    drive(8'h20, 1'b0); ovf_seen[1] = OVF_O;
    drive(8'h20, 1'b0); ovf_seen[2] = OVF_O;
    checks++;
    if (ovf_seen !== 3'b100 || PEND_O !== 8'h20) begin
      errors++;
      $display("FAIL ovf_pulse: got ovf=%b p=%h, expected 100 20", ovf_seen, PEND_O);
    end
    drive(8'h00, 1'b0);
    checks++;
    if (OVF_O !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %0b, expected 0", OVF_O);
    end
    for (int i = 0; i < 3; i++) drive(8'h00, 1'b1);
    checks++;
    if (hs_cnt[5] !== 2 || VALID_O !== 1'b0) begin
      errors++;
      $display("FAIL ovf_deliver: got %0d codes 5 v=%0b, expected 2 v=0", hs_cnt[5], VALID_O);
    end
  endtask

  task automatic test_all_bits();
    do_reset();
    drive(8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (!(VALID_O === 1'b1 && CODE_O === 3'(i))) begin
        errors++;
        $display("FAIL allbits_code%0d: got v=%0b c=%0d, expected v=1 c=%0d", i, VALID_O, CODE_O, i);
      end
      drive(8'h00, 1'b1);
    end
    checks++;
    if (VALID_O !== 1'b0) begin
      errors++;
      $display("FAIL allbits_idle: got v=%0b, expected 0", VALID_O);
    end
  endtask

  task automatic test_held_all();
    int exp;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(8'hFF, 1'b1);
`ifdef ENC_ROUND_ROBIN_EN
      exp = i % 8;
`else
      exp = 0;
`endif
      checks++;
      if (!(VALID_O === 1'b1 && CODE_O === 3'(exp))) begin
        errors++;
        $display("FAIL held_code%0d: got v=%0b c=%0d, expected v=1 c=%0d", i, VALID_O, CODE_O, exp);
      end
    end
  endtask

  task automatic test_random_loopback();
    logic [7:0] r;
    int n;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = 8'($urandom) & 8'($urandom) & 8'($urandom);
      drive(r, 1'($urandom_range(0, 3) != 0));
      checks++;
      if ({VALID_O, CODE_O, PEND_O, OVF_O} !== {m_valid, m_code, m_pend, m_ovf}) begin
        errors++;
        $display("FAIL rand_cyc%0d: got v=%0b c=%0d p=%h o=%0b, expected v=%0b c=%0d p=%h o=%0b",
                 i, VALID_O, CODE_O, PEND_O, OVF_O, m_valid, m_code, m_pend, m_ovf);
      end
    end
    n = 0;
    while (VALID_O === 1'b1 && n < 20) begin
      drive(8'h00, 1'b1);
      n++;
    end
    checks++;
    if (VALID_O !== 1'b0) begin
      errors++;
      $display("FAIL loop_drain: got v=%0b after %0d cycles, expected 0", VALID_O, n);
    end
    checks++;
    if (hs_or !== req_or) begin
      errors++;
      $display("FAIL loopback_or: got %h, expected %h", hs_or, req_or);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_backpressure();
    test_overflow();
    test_all_bits();
    test_held_all();
    test_random_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
